// File: rtl/whack_detector.sv
// Scores button strikes against raised moles; counts hits, misses and (with WHACK_ESCAPE_COUNT_EN) escapes.
// All outputs are registered one cycle after the sampled inputs; DONE freezes scoring until clear.
module whack_detector #(
  parameter int NUM_HOLES   = 18,
  parameter int SCORE_WIDTH = 10,
  parameter int MISS_WIDTH  = 6,
  parameter int MAX_MISSES  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_HOLES-1:0]   mole_positions,
  input  logic [NUM_HOLES-1:0]   buttons,
  input  logic                   clear,
  output logic [NUM_HOLES-1:0]   moles_live,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [MISS_WIDTH-1:0]  misses,
  output logic [SCORE_WIDTH-1:0] escapes,
  output logic                   game_over
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DONE = 2'd2} state_t;

  localparam logic [31:0] SCORE_SAT = 32'(2**SCORE_WIDTH - 1);
  localparam logic [31:0] MISS_LIM  = 32'(MAX_MISSES);

  function automatic logic [31:0] popcnt(input logic [NUM_HOLES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NUM_HOLES; i++) popcnt = popcnt + 32'(v[i]);
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_HOLES-1:0]   prev_pos_q, prev_pos_d, prev_btn_q, prev_btn_d;
  logic [NUM_HOLES-1:0]   whacked_q, whacked_d, live_q, live_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d, score_nxt;
  logic [MISS_WIDTH-1:0]  misses_q, misses_d, misses_nxt;
  logic                   hit_q, hit_d, miss_q, miss_d;

  logic [NUM_HOLES-1:0]   press, base, live_now, hits, miss_set;
  logic                   changed, miss_limit;
  logic [31:0]            score_sum, miss_sum;

  always_comb begin
    press      = buttons & ~prev_btn_q;
    changed    = (mole_positions != prev_pos_q);
    // A new wave forgets which moles were already struck.
    base       = changed ? '0 : whacked_q;
    live_now   = mole_positions & ~base;
    hits       = press & live_now;
    miss_set   = press & ~live_now;
    score_sum  = 32'(score_q) + popcnt(hits);
    miss_sum   = 32'(misses_q) + popcnt(miss_set);
    score_nxt  = (score_sum > SCORE_SAT) ? '1 : score_sum[SCORE_WIDTH-1:0];
    miss_limit = (miss_sum >= MISS_LIM);
    misses_nxt = miss_limit ? MISS_LIM[MISS_WIDTH-1:0] : miss_sum[MISS_WIDTH-1:0];
  end

  always_comb begin
    prev_pos_d = mole_positions;
    prev_btn_d = buttons;
    whacked_d  = whacked_q;
    score_d    = score_q;
    misses_d   = misses_q;
    live_d     = '0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    if (clear) begin
      whacked_d = '0;
      score_d   = '0;
      misses_d  = '0;
    end else if (state_q != DONE) begin
      whacked_d = base | hits;
      score_d   = score_nxt;
      misses_d  = misses_nxt;
      live_d    = live_now & ~hits;
      hit_d     = |hits;
      miss_d    = |miss_set;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, UP: begin
        if (miss_limit)                state_d = DONE;
        else if (mole_positions != '0) state_d = UP;
        else                           state_d = IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    game_over = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_pos_q <= '0;
      prev_btn_q <= '1;
      whacked_q  <= '0;
      live_q     <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_pos_q <= prev_pos_d;
      prev_btn_q <= prev_btn_d;
      whacked_q  <= whacked_d;
      live_q     <= live_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

`ifdef WHACK_ESCAPE_COUNT_EN
  logic [SCORE_WIDTH-1:0] escapes_q, escapes_d;
  logic [31:0]            esc_sum;

  // Moles of the outgoing wave that were never struck escaped.
  always_comb begin
    esc_sum   = 32'(escapes_q) +
                ((changed && prev_pos_q != '0) ? popcnt(prev_pos_q & ~whacked_q) : 32'd0);
    escapes_d = escapes_q;
    if (clear)                escapes_d = '0;
    else if (state_q != DONE) escapes_d = (esc_sum > SCORE_SAT) ? '1 : esc_sum[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) escapes_q <= '0;
    else        escapes_q <= escapes_d;
  end

  assign escapes = escapes_q;
`else
  assign escapes = '0;
`endif

  assign moles_live = live_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign misses     = misses_q;

endmodule
